fifo_write_arbiter: RTL and testbench

- Shares one fifo_sync write port among N_REQ producers (e.g. per-channel DAC/ADC command streams on the LCB).
- Round-robin arbitration at packet granularity: once granted, a requester holds the port until it transfers a word with last=1 or hits MAX_BURST words.
- Registered write outputs drive fifo_sync wr_data/wr_en. Back-pressure uses fifo_sync almost_full, which must be instantiated with ALMOST_FULL_THRESHOLD=1.

---
 rtl/fifo_write_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares one fifo_sync write port among N_REQ producers.
//
// Round-robin arbitration at packet granularity. A holder keeps the port until
// it transfers a word with last=1 or has moved MAX_BURST words. Every grant is
// followed by one idle cycle before the next one. The write outputs are
// registered and add one cycle of latency. Back-pressure uses fifo_sync
// almost_full, and the FIFO must be built with ALMOST_FULL_THRESHOLD=1.
//
// Optional feature: define FIFO_ARB_WATCHDOG_EN to enable an idle watchdog.
// When it is enabled, a holder that leaves req_valid low for TIMEOUT_CYCLES
// cycles loses the grant and the sticky timeout_err_o is set. When it is not
// defined, timeout_err_o is tied to 0 and a grant is held for as long as needed.
//
// Ports:
//   clk_i, resetn_i          clock, asynchronous active-low reset
//   req_valid_i/last_i       per-requester word valid / end of packet
//   req_data_i               flattened, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o              per-requester accept
//   fifo_wr_data_o/wr_en_o   registered fifo_sync write port
//   fifo_full_i              fifo_sync full
//   fifo_almost_full_i       fifo_sync almost_full
//   grant_valid_o/grant_id_o current holder (id is 0 when there is no holder)
//   overflow_err_o           sticky: write issued while the FIFO was full
//   timeout_err_o            sticky watchdog flag
module fifo_write_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned MAX_BURST      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                      clk_i,
  input  logic                                      resetn_i,
  input  logic [N_REQ-1:0]                          req_valid_i,
  input  logic [N_REQ-1:0]                          req_last_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]               req_data_i,
  output logic [N_REQ-1:0]                          req_ready_o,
  output logic [DATA_WIDTH-1:0]                     fifo_wr_data_o,
  output logic                                      fifo_wr_en_o,
  input  logic                                      fifo_full_i,
  input  logic                                      fifo_almost_full_i,
  output logic                                      grant_valid_o,
  output logic [(N_REQ > 1 ? $clog2(N_REQ) : 1)-1:0] grant_id_o,
  output logic                                      overflow_err_o,
  output logic                                      timeout_err_o
);

  localparam int unsigned IdW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e                state_q;
  logic [IdW-1:0]        rr_ptr_q;
  logic [IdW-1:0]        grant_id_q;
  logic                  grant_valid_q;
  logic [CntW-1:0]       burst_cnt_q;
  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  overflow_q;

  logic [IdW-1:0]        pick_id;
  logic                  pick_found;
  int                    idx;
  logic [IdW-1:0]        next_ptr;
  logic                  holder_valid;
  logic                  holder_last;
  logic [DATA_WIDTH-1:0] holder_data;
  logic                  xfer;
  logic                  burst_done;

  // First valid requester at or after rr_ptr_q, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = (int'(rr_ptr_q) + k) % int'(N_REQ);
      if (!pick_found && req_valid_i[idx]) begin
        pick_found = 1'b1;
        pick_id    = IdW'(idx);
      end
    end
  end

  assign holder_valid = req_valid_i[grant_id_q];
  assign holder_last  = req_last_i[grant_id_q];
  assign holder_data  = req_data_i[int'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH];

  // Stall on almost_full. At most one write is in flight that the FIFO count
  // does not yet show, so the FIFO is never written while it is full.
  always_comb begin
    req_ready_o = '0;
    if (state_q == StBurst) req_ready_o[grant_id_q] = ~fifo_almost_full_i;
  end

  assign xfer       = (state_q == StBurst) && holder_valid && !fifo_almost_full_i;
  assign burst_done = (burst_cnt_q >= CntW'(MAX_BURST - 1));
  assign next_ptr   = (grant_id_q == IdW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

`ifdef FIFO_ARB_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] idle_cnt_q;
  logic           timeout_q;
  logic           wd_fire;
  assign wd_fire = (state_q == StBurst) && !holder_valid &&
                   (idle_cnt_q == WdW'(TIMEOUT_CYCLES - 1));
  assign timeout_err_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      overflow_q    <= 1'b0;
`ifdef FIFO_ARB_WATCHDOG_EN
      idle_cnt_q    <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      wr_en_q    <= 1'b0;
      overflow_q <= overflow_q | (wr_en_q & fifo_full_i);
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            grant_id_q    <= pick_id;
            grant_valid_q <= 1'b1;
            burst_cnt_q   <= '0;
            state_q       <= StBurst;
`ifdef FIFO_ARB_WATCHDOG_EN
            idle_cnt_q    <= '0;
`endif
          end
        end
        StBurst: begin
`ifdef FIFO_ARB_WATCHDOG_EN
          if (holder_valid) idle_cnt_q <= '0;
          else              idle_cnt_q <= idle_cnt_q + 1'b1;
`endif
          if (xfer) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= holder_data;
            if (holder_last || burst_done) begin
              rr_ptr_q      <= next_ptr;
              grant_valid_q <= 1'b0;
              grant_id_q    <= '0;
              burst_cnt_q   <= '0;
              state_q       <= StIdle;
            end else if (burst_cnt_q != CntW'(MAX_BURST)) begin
              burst_cnt_q <= burst_cnt_q + 1'b1;
            end
          end
`ifdef FIFO_ARB_WATCHDOG_EN
          else if (wd_fire) begin
            rr_ptr_q      <= next_ptr;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            burst_cnt_q   <= '0;
            idle_cnt_q    <= '0;
            timeout_q     <= 1'b1;
            state_q       <= StIdle;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fifo_wr_en_o   = wr_en_q;
  assign fifo_wr_data_o = wr_data_q;
  assign grant_valid_o  = grant_valid_q;
  assign grant_id_o     = grant_id_q;
  assign overflow_err_o = overflow_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter. It contains requester source models and
// a behavioural depth-16 fifo_sync model (almost_full when count >= 15).
module tb_fifo_write_arbiter;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [63:0] req_data;
  logic [15:0] fifo_wr_data;
  logic        fifo_wr_en, fifo_full, fifo_almost_full;
  logic        grant_valid, overflow_err, timeout_err;
  logic [1:0]  grant_id;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .N_REQ(4), .DATA_WIDTH(16), .MAX_BURST(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .resetn_i(resetn),
    .req_valid_i(req_valid), .req_last_i(req_last), .req_data_i(req_data),
    .req_ready_o(req_ready),
    .fifo_wr_data_o(fifo_wr_data), .fifo_wr_en_o(fifo_wr_en),
    .fifo_full_i(fifo_full), .fifo_almost_full_i(fifo_almost_full),
    .grant_valid_o(grant_valid), .grant_id_o(grant_id),
    .overflow_err_o(overflow_err), .timeout_err_o(timeout_err)
  );

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int words_left[4], pkts_left[4], pkt_len[4], sent[4];
  bit use_last[4];
  int fcount;
  bit rd_en, force_full;
  logic [15:0] wlog[$];
  int wcyc[$];
  int glog[$];
  logic gv_prev;
  logic [15:0] exp_t2[10] = '{16'h0000, 16'h0001, 16'h1000, 16'h1001, 16'h2000,
                              16'h2001, 16'h3000, 16'h3001, 16'h0002, 16'h0003};
  int exp_g2[5] = '{0, 1, 2, 3, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (words_left[i] > 0);
      req_last[i]  = use_last[i] && (words_left[i] == 1);
      req_data[i*16 +: 16] = {4'(i), 12'(sent[i])};
    end
  endtask

  task automatic update_flags();
    fifo_full        = (fcount >= DEPTH) || force_full;
    fifo_almost_full = (fcount >= DEPTH - 1);
  endtask

  // One clock: sample handshakes at the negedge, then update the models after the posedge.
  task automatic cycle();
    logic [3:0]  fired;
    logic        wen;
    logic [15:0] wdat;
    bit          rd;
    @(negedge clk);
    fired = req_valid & req_ready;
    wen   = fifo_wr_en;
    wdat  = fifo_wr_data;
    rd    = rd_en;
    @(posedge clk);
    #1;
    cyc++;
    if (wen && fcount < DEPTH) begin
      fcount++;
      wlog.push_back(wdat);
      wcyc.push_back(cyc);
    end
    if (rd && fcount > 0) fcount--;
    for (int i = 0; i < 4; i++) begin
      if (fired[i]) begin
        sent[i]++;
        words_left[i]--;
        if (words_left[i] == 0) begin
          pkts_left[i]--;
          if (pkts_left[i] > 0) words_left[i] = pkt_len[i];
        end
      end
    end
    drive();
    update_flags();
    if (grant_valid && !gv_prev) glog.push_back(int'(grant_id));
    gv_prev = grant_valid;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic load(input int i, input int len, input int npk, input bit last);
    pkt_len[i]    = len;
    pkts_left[i]  = npk;
    words_left[i] = len;
    use_last[i]   = last;
    sent[i]       = 0;
    drive();
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      words_left[i] = 0; pkts_left[i] = 0; pkt_len[i] = 0; sent[i] = 0; use_last[i] = 0;
    end
    rd_en = 0; force_full = 0; fcount = 0;
    wlog.delete(); wcyc.delete(); glog.delete();
    gv_prev = 1'b0;
    drive();
    update_flags();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_all();
    run(2);
    resetn = 1'b1;
    glog.delete();
    gv_prev = 1'b0;
  endtask

  initial begin
    int n;
    resetn = 1'b1;
    clear_all();
    #2 resetn = 1'b0;
    #1;
    check("rst_wr_en",     32'(fifo_wr_en),   0);
    check("rst_wr_data",   32'(fifo_wr_data), 0);
    check("rst_gvalid",    32'(grant_valid),  0);
    check("rst_gid",       32'(grant_id),     0);
    check("rst_ready",     32'(req_ready),    0);
    check("rst_overflow",  32'(overflow_err), 0);
    check("rst_timeout",   32'(timeout_err),  0);
    run(2);
    resetn = 1'b1;

    // Reset mid-burst: requester 2 has moved 3 words and the third write is in flight.
    load(2, 6, 1, 1);
    n = 0;
    while (sent[2] < 3 && n < 20) begin cycle(); n++; end
    check("t1_sent", 32'(sent[2]), 3);
    check("t1_inflight", 32'(fifo_wr_en), 1);
    load(0, 2, 1, 1);
    resetn = 1'b0;
    #1;
    check("t1_rst_wr_en",  32'(fifo_wr_en),   0);
    check("t1_rst_gvalid", 32'(grant_valid),  0);
    check("t1_rst_gid",    32'(grant_id),     0);
    check("t1_rst_ready",  32'(req_ready),    0);
    check("t1_rst_data",   32'(fifo_wr_data), 0);
    run(1);
    resetn = 1'b1;
    glog.delete();
    gv_prev = 1'b0;
    run(1);
    check("t1_gvalid", 32'(grant_valid), 1);
    check("t1_gid",    32'(grant_id),    0);
    check("t1_writes", 32'(wlog.size()), 2);

    // Four requesters, 2-word packets; requester 0 has a second packet.
    do_reset();
    load(0, 2, 2, 1);
    for (int i = 1; i < 4; i++) load(i, 2, 1, 1);
    run(24);
    check("t2_ngrants", 32'(glog.size()), 5);
    for (int k = 0; k < 5 && k < glog.size(); k++) check("t2_gorder", 32'(glog[k]), 32'(exp_g2[k]));
    check("t2_nwrites", 32'(wlog.size()), 10);
    for (int k = 0; k < 10 && k < wlog.size(); k++) check("t2_data", 32'(wlog[k]), 32'(exp_t2[k]));
    for (int k = 0; k < 9 && k + 1 < wcyc.size(); k++)
      check("t2_gap", 32'(wcyc[k+1] - wcyc[k]), (k % 2 == 0) ? 1 : 2);
    check("t2_idle", 32'(grant_valid), 0);

    // Requester 1 streams 40 words with no last; each grant is cut at 16 words.
    do_reset();
    rd_en = 1;
    load(1, 40, 1, 0);
    run(60);
    check("t3_ngrants", 32'(glog.size()), 3);
    for (int k = 0; k < 3 && k < glog.size(); k++) check("t3_gid", 32'(glog[k]), 1);
    check("t3_nwrites", 32'(wlog.size()), 40);
    for (int k = 0; k < 40 && k < wlog.size(); k++) check("t3_data", 32'(wlog[k]), 32'h1000 + k);
    if (wcyc.size() == 40) begin
      check("t3_gap15", 32'(wcyc[15] - wcyc[14]), 1);
      check("t3_gap16", 32'(wcyc[16] - wcyc[15]), 2);
      check("t3_gap32", 32'(wcyc[32] - wcyc[31]), 2);
    end
    check("t3_held_valid", 32'(grant_valid), 1);
    check("t3_held_id",    32'(grant_id),    1);
    check("t3_timeout",    32'(timeout_err), 0);

    // FIFO back-pressure: no reads, 20-word packet into a depth-16 FIFO.
    do_reset();
    load(0, 20, 1, 1);
    run(40);
    check("t4_nwrites",  32'(wlog.size()),      16);
    check("t4_fcount",   32'(fcount),           16);
    check("t4_af",       32'(fifo_almost_full), 1);
    check("t4_ready",    32'(req_ready),        0);
    check("t4_gvalid",   32'(grant_valid),      1);
    check("t4_overflow", 32'(overflow_err),     0);
    rd_en = 1;
    run(4);
    rd_en = 0;
    run(20);
    check("t4_nwrites2",  32'(wlog.size()),  20);
    check("t4_fcount2",   32'(fcount),       16);
    check("t4_overflow2", 32'(overflow_err), 0);
    check("t4_done",      32'(grant_valid),  0);
    for (int k = 0; k < 20 && k < wlog.size(); k++) check("t4_data", 32'(wlog[k]), k);

    // Fault injection: full is asserted while almost_full is low, so a write is issued into a full FIFO.
    do_reset();
    force_full = 1;
    update_flags();
    load(2, 1, 1, 1);
    run(4);
    check("t5_overflow", 32'(overflow_err), 1);
    force_full = 0;
    update_flags();
    run(5);
    check("t5_sticky", 32'(overflow_err), 1);
    resetn = 1'b0;
    #1;
    check("t5_cleared", 32'(overflow_err), 0);
    run(1);
    resetn = 1'b1;

    // Holder sends one word and then drops valid while requester 0 is pending.
    do_reset();
    load(3, 1, 1, 0);
    n = 0;
    while (sent[3] < 1 && n < 10) begin cycle(); n++; end
    check("t6_sent", 32'(sent[3]), 1);
    load(0, 1, 1, 1);
    run(14);
`ifdef FIFO_ARB_WATCHDOG_EN
    check("t6_timeout", 32'(timeout_err), 1);
    check("t6_ngrants", 32'(glog.size()), 2);
    if (glog.size() == 2) check("t6_next", 32'(glog[1]), 0);
    check("t6_r0_sent", 32'(sent[0]), 1);
`else
    check("t6_timeout", 32'(timeout_err), 0);
    check("t6_held",    32'(grant_valid), 1);
    check("t6_gid",     32'(grant_id),    3);
    check("t6_r0_wait", 32'(sent[0]),     0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
